sm4_key_expander: RTL and testbench
===================================

SM4_KEY_EXPANDER -- requirements
Module: sm4_key_expander

Interface
REQ-001 Parameter rounds_per_cycle_p, default 1: SM4 key-schedule rounds evaluated per clock; legal values are 1, 2, 4 and 8.
REQ-002 Parameter reg_read_p, default 0: 0 gives a combinational read port; 1 gives a registered read port with 1-cycle latency.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_i  input  1  reset, asynchronous and active-high.
REQ-005 clear_i  input  1  synchronous invalidate of the stored schedule and abort of any expansion in progress.
REQ-006 key_v_i  input  1  master key valid.
REQ-007 key_i  input  128  master key; MK0=[127:96], MK1=[95:64], MK2=[63:32], MK3=[31:0].
REQ-008 key_ready_o  output  1  block can accept a master key this cycle.
REQ-009 keys_valid_o  output  1  all 32 round keys are stored and readable.
REQ-010 done_o  output  1  one-cycle pulse when expansion completes.
REQ-011 rk_addr_i  input  5  round-key index to read.
REQ-012 decrypt_i  input  1  reverse read order: the effective index becomes 31-rk_addr_i.
REQ-013 rk_o  output  32  selected round key.

Function
REQ-014 Algorithm: K0..K3 = MK0..MK3 XOR FK0..FK3 (FK0=A3B1BAC6, FK1=56AA3350, FK2=677D9197, FK3=B27022DC).
REQ-015 Each round computes rk_i = K(i+4) = K(i) XOR T'(K(i+1)^K(i+2)^K(i+3)^CK_i).
REQ-016 T' is the byte-wise SM4 S-box followed by L'(B) = B ^ (B<<<13) ^ (B<<<23).
REQ-017 CK_i byte j (j=0 is the MSB) is (4i+j)*7 mod 256, so CK0=00070E15 and CK31=646B7279.
REQ-018 The state machine has three states: eIdle (no valid schedule), eEval (expanding) and eReady (schedule valid).
REQ-019 key_ready_o is high in eIdle and eReady while clear_i is low; it is low in eEval and whenever clear_i is high.
REQ-020 A handshake occurs on key_v_i & key_ready_o; at that edge K0..K3 are registered, the round counter is zeroed and the state moves to eEval.
REQ-021 In eEval, each cycle writes rounds_per_cycle_p consecutive round keys into a 32x32 store and advances the counter by rounds_per_cycle_p.
REQ-022 Expansion takes N = 32/rounds_per_cycle_p cycles; keys_valid_o and done_o assert N cycles after the handshake edge, and the state moves to eReady.
REQ-023 A handshake in eReady is a rekey: keys_valid_o drops on the next cycle and the old schedule is no longer readable.
REQ-024 key_v_i while in eEval is ignored; no stall or error is raised.
REQ-025 clear_i has priority over key_v_i and expansion: next state is eIdle, keys_valid_o is 0 and the counter is 0.
REQ-026 clear_i in eIdle has no effect.
REQ-027 Read port, reg_read_p=0: rk_o = store[decrypt_i ? 31-rk_addr_i : rk_addr_i] when keys_valid_o=1, else 0.
REQ-028 Read port, reg_read_p=1: the same value is registered one cycle later and gated by the registered keys_valid_o.
REQ-029 The counter never wraps; the final batch ends exactly at index 31.
REQ-030 All XOR and rotate arithmetic is modulo 2^32; there are no carries.

Reset
REQ-031 Asynchronous assertion of reset_i forces: state eIdle, counter 0, keys_valid_o=0, done_o=0, rk_o=0 and the registered read stage 0.
REQ-032 key_ready_o may assert only after reset_i deasserts.
REQ-033 The round-key store is not reset; it is unobservable until a fresh expansion completes.
REQ-034 Reset asserted mid-expansion abandons the expansion; no partial keys are ever readable.

Verification
REQ-035 key_i=0123456789ABCDEFFEDCBA9876543210 with rounds_per_cycle_p=1 -> keys_valid_o high 32 cycles after the handshake, rk[0]=F12186F9, rk[31]=9124A012.
REQ-036 Same key with rounds_per_cycle_p=8 -> keys_valid_o high 4 cycles after the handshake; all 32 keys identical to the rounds_per_cycle_p=1 run.
REQ-037 decrypt_i=1 with rk_addr_i=0 -> rk_o=9124A012; rk_addr_i=31 -> rk_o=F12186F9; with reg_read_p=1 each value appears 1 cycle later.
REQ-038 key_v_i held high through eEval with a second key -> second key ignored; after done_o, a fresh handshake drops keys_valid_o the next cycle and a new schedule is produced.
REQ-039 clear_i and key_v_i high in the same eReady cycle -> eIdle, key not accepted, rk_o=0.
REQ-040 reset_i pulsed at cycle 10 of an expansion -> all outputs 0 immediately; no done_o pulse; a subsequent key expands correctly.

Source files
------------

// File: rtl/sm4_key_expander.sv
// sm4_key_expander
//   Expands a 128-bit SM4 master key into the 32 round keys, evaluating
//   rounds_per_cycle_p rounds per clock, and serves them from a 32x32 store.
//
//   Parameters
//     rounds_per_cycle_p  rounds per clock (1, 2, 4 or 8); expansion takes 32/rounds_per_cycle_p cycles
//     reg_read_p          0: combinational read port, 1: read port registered (1-cycle latency)
//
//   Ports
//     clk_i, reset_i      clock, asynchronous active-high reset
//     clear_i             synchronous invalidate / abort
//     key_v_i, key_i      master key offer (MK0 = key_i[127:96] .. MK3 = key_i[31:0])
//     key_ready_o         key can be accepted this cycle
//     keys_valid_o        full schedule stored and readable
//     done_o              one-cycle pulse when expansion completes
//     rk_addr_i           round-key index
//     decrypt_i           read index becomes 31-rk_addr_i
//     rk_o                selected round key (0 while no valid schedule)
module sm4_key_expander #(
    parameter int rounds_per_cycle_p = 1,
    parameter int reg_read_p         = 0
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         clear_i,
    input  logic         key_v_i,
    input  logic [127:0] key_i,
    output logic         key_ready_o,
    output logic         keys_valid_o,
    output logic         done_o,
    input  logic [4:0]   rk_addr_i,
    input  logic         decrypt_i,
    output logic [31:0]  rk_o
);
    localparam int R = rounds_per_cycle_p;
    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    // One key-schedule round. w[0]=K(i) .. w[3]=K(i+3); returns K(i+4).
    function automatic logic [31:0] ks_round(input logic [3:0][31:0] w, input logic [4:0] i);
        logic [31:0] ck;
        logic [31:0] x;
        logic [31:0] b;
        ck = '0;
        b  = '0;
        // CK byte n (n=0 is the MSB) is (4i+n)*7 mod 256
        for (int n = 0; n < 4; n++)
            ck[31-8*n -: 8] = 8'((32'(i) * 4 + 32'(n)) * 7);
        x = w[1] ^ w[2] ^ w[3] ^ ck;
        for (int n = 0; n < 4; n++)
            b[8*n +: 8] = SBOX[x[8*n +: 8]];
        // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
        return w[0] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    typedef enum logic [1:0] {eIdle, eEval, eReady} state_e;

    state_e            state;
    logic [5:0]        cnt;        // index of the next round; reaches 32 on completion, never wraps
    logic [3:0][31:0]  kwin;       // sliding window K(cnt)..K(cnt+3), kwin[0] oldest
    logic [3:0][31:0]  kwin_nxt;
    logic [R-1:0][31:0] rk;
    logic [31:0]       store [32];
    logic              hs;
    logic [127:0]      k0;

    assign key_ready_o = ~reset_i & ~clear_i & (state != eEval);
    assign hs          = key_v_i & key_ready_o;
    assign k0          = key_i ^ FK;

    // Chain R rounds through the window in one cycle.
    always_comb begin
        kwin_nxt = kwin;
        rk       = '0;
        for (int j = 0; j < R; j++) begin
            rk[j]    = ks_round(kwin_nxt, cnt[4:0] + 5'(j));
            kwin_nxt = {rk[j], kwin_nxt[3:1]};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= eIdle;
            cnt          <= '0;
            kwin         <= '0;
            keys_valid_o <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (clear_i) begin
                state        <= eIdle;
                cnt          <= '0;
                keys_valid_o <= 1'b0;
            end else begin
                case (state)
                    eIdle, eReady: begin
                        if (hs) begin
                            kwin         <= {k0[31:0], k0[63:32], k0[95:64], k0[127:96]};
                            cnt          <= '0;
                            keys_valid_o <= 1'b0;
                            state        <= eEval;
                        end
                    end
                    eEval: begin
                        kwin <= kwin_nxt;
                        cnt  <= cnt + 6'(R);
                        if (cnt == 6'(32 - R)) begin
                            state        <= eReady;
                            keys_valid_o <= 1'b1;
                            done_o       <= 1'b1;
                        end
                    end
                    default: state <= eIdle;
                endcase
            end
        end
    end

    // Schedule storage is deliberately unreset; keys_valid_o gates every read.
    always_ff @(posedge clk_i) begin
        if (state == eEval && !clear_i && !reset_i)
            for (int j = 0; j < R; j++)
                store[cnt[4:0] + 5'(j)] <= rk[j];
    end

    logic [4:0]  ridx;
    logic [31:0] rd;
    assign ridx = decrypt_i ? (5'd31 - rk_addr_i) : rk_addr_i;
    assign rd   = keys_valid_o ? store[ridx] : '0;

    generate
        if (reg_read_p != 0) begin : g_rreg
            // Registering the already-gated value is the same as gating the
            // registered value with the registered keys_valid_o.
            logic [31:0] rd_q;
            always_ff @(posedge clk_i or posedge reset_i) begin
                if (reset_i) rd_q <= '0;
                else         rd_q <= rd;
            end
            assign rk_o = rd_q;
        end else begin : g_rcomb
            assign rk_o = rd;
        end
    endgenerate

endmodule

// File: tb/tb_sm4_key_expander.sv
// tb_sm4_key_expander
//   Drives two expanders from the same stimulus: dut_a (1 round/cycle,
//   combinational read) and dut_b (8 rounds/cycle, registered read).
//   Stimulus queues expected responses tagged with the cycle they are due;
//   a negedge monitor compares and counts.
module tb_sm4_key_expander;
    logic         clk = 1'b0;
    logic         reset_i = 1'b1;
    logic         clear_i = 1'b0;
    logic         key_v_i = 1'b0;
    logic [127:0] key_i = '0;
    logic [4:0]   rk_addr_i = '0;
    logic         decrypt_i = 1'b0;
    logic         kr_a, kv_a, dn_a, kr_b, kv_b, dn_b;
    logic [31:0]  rk_a, rk_b;

    always #5 clk = ~clk;

    sm4_key_expander #(.rounds_per_cycle_p(1), .reg_read_p(0)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .key_v_i(key_v_i), .key_i(key_i),
        .key_ready_o(kr_a), .keys_valid_o(kv_a), .done_o(dn_a),
        .rk_addr_i(rk_addr_i), .decrypt_i(decrypt_i), .rk_o(rk_a));

    sm4_key_expander #(.rounds_per_cycle_p(8), .reg_read_p(1)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i), .key_v_i(key_v_i), .key_i(key_i),
        .key_ready_o(kr_b), .keys_valid_o(kv_b), .done_o(dn_b),
        .rk_addr_i(rk_addr_i), .decrypt_i(decrypt_i), .rk_o(rk_b));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int RK_A = 0, RK_B = 1, KV_A = 2, KV_B = 3, KR_A = 4, KR_B = 5, DN_A = 6, DN_B = 7;
    string sig_name [8] = '{"rk_a", "rk_b", "keys_valid_a", "keys_valid_b",
                            "key_ready_a", "key_ready_b", "done_a", "done_b"};

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
    } exp_t;

    typedef logic [31:0][31:0] sched_t;

    exp_t expq[$];
    int   done_a_q[$];
    int   done_b_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] sbox [256] = '{
        'hd6,'h90,'he9,'hfe,'hcc,'he1,'h3d,'hb7,'h16,'hb6,'h14,'hc2,'h28,'hfb,'h2c,'h05,
        'h2b,'h67,'h9a,'h76,'h2a,'hbe,'h04,'hc3,'haa,'h44,'h13,'h26,'h49,'h86,'h06,'h99,
        'h9c,'h42,'h50,'hf4,'h91,'hef,'h98,'h7a,'h33,'h54,'h0b,'h43,'hed,'hcf,'hac,'h62,
        'he4,'hb3,'h1c,'ha9,'hc9,'h08,'he8,'h95,'h80,'hdf,'h94,'hfa,'h75,'h8f,'h3f,'ha6,
        'h47,'h07,'ha7,'hfc,'hf3,'h73,'h17,'hba,'h83,'h59,'h3c,'h19,'he6,'h85,'h4f,'ha8,
        'h68,'h6b,'h81,'hb2,'h71,'h64,'hda,'h8b,'hf8,'heb,'h0f,'h4b,'h70,'h56,'h9d,'h35,
        'h1e,'h24,'h0e,'h5e,'h63,'h58,'hd1,'ha2,'h25,'h22,'h7c,'h3b,'h01,'h21,'h78,'h87,
        'hd4,'h00,'h46,'h57,'h9f,'hd3,'h27,'h52,'h4c,'h36,'h02,'he7,'ha0,'hc4,'hc8,'h9e,
        'hea,'hbf,'h8a,'hd2,'h40,'hc7,'h38,'hb5,'ha3,'hf7,'hf2,'hce,'hf9,'h61,'h15,'ha1,
        'he0,'hae,'h5d,'ha4,'h9b,'h34,'h1a,'h55,'had,'h93,'h32,'h30,'hf5,'h8c,'hb1,'he3,
        'h1d,'hf6,'he2,'h2e,'h82,'h66,'hca,'h60,'hc0,'h29,'h23,'hab,'h0d,'h53,'h4e,'h6f,
        'hd5,'hdb,'h37,'h45,'hde,'hfd,'h8e,'h2f,'h03,'hff,'h6a,'h72,'h6d,'h6c,'h5b,'h51,
        'h8d,'h1b,'haf,'h92,'hbb,'hdd,'hbc,'h7f,'h11,'hd9,'h5c,'h41,'h1f,'h10,'h5a,'hd8,
        'h0a,'hc1,'h31,'h88,'ha5,'hcd,'h7b,'hbd,'h2d,'h74,'hd0,'h12,'hb8,'he5,'hb4,'hb0,
        'h89,'h69,'h97,'h4a,'h0c,'h96,'h77,'h7e,'h65,'hb9,'hf1,'h09,'hc5,'h6e,'hc6,'h84,
        'h18,'hf0,'h7d,'hec,'h3a,'hdc,'h4d,'h20,'h79,'hee,'h5f,'h3e,'hd7,'hcb,'h39,'h48
    };

    // Reference key schedule: straight from the algorithm with a 36-word K array.
    function automatic sched_t ref_expand(input logic [127:0] mk);
        logic [31:0] k [36];
        logic [31:0] x, t;
        sched_t      s;
        k[0] = mk[127:96] ^ 32'hA3B1BAC6;
        k[1] = mk[95:64]  ^ 32'h56AA3350;
        k[2] = mk[63:32]  ^ 32'h677D9197;
        k[3] = mk[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            x = 32'd0;
            for (int j = 0; j < 4; j++)
                x = (x << 8) | 32'(((4 * i + j) * 7) % 256);
            x = x ^ k[i+1] ^ k[i+2] ^ k[i+3];
            t = 32'd0;
            for (int j = 3; j >= 0; j--)
                t = (t << 8) | 32'(sbox[8'(x >> (8 * j))]);
            k[i+4] = k[i] ^ t ^ ((t << 13) | (t >> 19)) ^ ((t << 23) | (t >> 9));
            s[i] = k[i+4];
        end
        return s;
    endfunction

    function automatic logic [31:0] act_of(input int s);
        case (s)
            RK_A:    return rk_a;
            RK_B:    return rk_b;
            KV_A:    return {31'd0, kv_a};
            KV_B:    return {31'd0, kv_b};
            KR_A:    return {31'd0, kr_a};
            KR_B:    return {31'd0, kr_b};
            DN_A:    return {31'd0, dn_a};
            default: return {31'd0, dn_b};
        endcase
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: done pulses against the done queues, everything else against expq.
    always @(negedge clk) begin
        if (dn_a) begin
            if (done_a_q.size() == 0) cmp("done_a_unexpected", {31'd0, dn_a}, 32'd0);
            else begin
                cmp("done_a_cycle", cyc, done_a_q[0]);
                cmp("keys_valid_a_at_done", {31'd0, kv_a}, 32'd1);
                void'(done_a_q.pop_front());
            end
        end else if (done_a_q.size() != 0 && done_a_q[0] <= cyc) begin
            cmp("done_a_missing", {31'd0, dn_a}, 32'd1);
            void'(done_a_q.pop_front());
        end
        if (dn_b) begin
            if (done_b_q.size() == 0) cmp("done_b_unexpected", {31'd0, dn_b}, 32'd0);
            else begin
                cmp("done_b_cycle", cyc, done_b_q[0]);
                cmp("keys_valid_b_at_done", {31'd0, kv_b}, 32'd1);
                void'(done_b_q.pop_front());
            end
        end else if (done_b_q.size() != 0 && done_b_q[0] <= cyc) begin
            cmp("done_b_missing", {31'd0, dn_b}, 32'd1);
            void'(done_b_q.pop_front());
        end
        for (int i = expq.size() - 1; i >= 0; i--) begin
            if (expq[i].cyc <= cyc) begin
                cmp(sig_name[expq[i].sig], act_of(expq[i].sig), expq[i].val);
                expq.delete(i);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int s, input logic [31:0] v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        expq.push_back(e);
    endtask

    // Handshake k; then optionally keep offering k2 for 'hold' cycles while both are busy.
    task automatic send_key(input logic [127:0] k, input int hold, input logic [127:0] k2);
        expect_at(cyc, KR_A, 1);
        expect_at(cyc, KR_B, 1);
        key_i   = k;
        key_v_i = 1'b1;
        done_a_q.push_back(cyc + 1 + 32);
        done_b_q.push_back(cyc + 1 + 4);
        step();
        expect_at(cyc, KV_A, 0);
        expect_at(cyc, KV_B, 0);
        expect_at(cyc, RK_A, 0);
        expect_at(cyc + 1, RK_B, 0);
        for (int i = 0; i < hold; i++) begin
            key_i = k2;
            expect_at(cyc, KR_A, 0);
            expect_at(cyc, KR_B, 0);
            step();
        end
        key_v_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && (done_a_q.size() != 0 || done_b_q.size() != 0); i++)
            step();
        step();
    endtask

    task automatic read_one(input logic [4:0] a, input logic dec, input logic [31:0] exp);
        rk_addr_i = a;
        decrypt_i = dec;
        expect_at(cyc, RK_A, exp);
        expect_at(cyc + 1, RK_B, exp);
        step();
    endtask

    task automatic sweep(input sched_t s, input logic valid);
        logic dec;
        for (int a = 0; a < 32; a++) begin
            dec = 1'($urandom_range(0, 1));
            read_one(5'(a), dec, valid ? s[dec ? 31 - a : a] : 32'd0);
        end
        step();
    endtask

    sched_t       s;
    logic [127:0] k;
    int           h;

    initial begin
        // Reset state
        step();
        expect_at(cyc, KR_A, 0); expect_at(cyc, KR_B, 0);
        expect_at(cyc, KV_A, 0); expect_at(cyc, KV_B, 0);
        expect_at(cyc, DN_A, 0); expect_at(cyc, DN_B, 0);
        expect_at(cyc, RK_A, 0); expect_at(cyc, RK_B, 0);
        step();
        reset_i = 1'b0;
        expect_at(cyc, KR_A, 1); expect_at(cyc, KR_B, 1);
        step();

        // Known-answer key
        k = 128'h0123456789ABCDEFFEDCBA9876543210;
        send_key(k, 0, '0);
        wait_done();
        read_one(5'd0,  1'b0, 32'hF12186F9);
        read_one(5'd31, 1'b0, 32'h9124A012);
        read_one(5'd0,  1'b1, 32'h9124A012);
        read_one(5'd31, 1'b1, 32'hF12186F9);
        step();
        sweep(ref_expand(k), 1'b1);

        // Key offered throughout expansion is ignored
        k = {$urandom, $urandom, $urandom, $urandom};
        send_key(k, 4, {$urandom, $urandom, $urandom, $urandom});
        wait_done();
        sweep(ref_expand(k), 1'b1);

        // Rekey from eReady plus random keys
        for (int n = 0; n < 4; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            if (n == 3) k = '1;
            send_key(k, 0, '0);
            wait_done();
            sweep(ref_expand(k), 1'b1);
        end
        s = ref_expand(k);

        // clear_i with key_v_i in eReady: clear wins, key is not taken
        rk_addr_i = 5'd5;
        decrypt_i = 1'b0;
        clear_i   = 1'b1;
        key_v_i   = 1'b1;
        key_i     = {$urandom, $urandom, $urandom, $urandom};
        expect_at(cyc, KR_A, 0); expect_at(cyc, KR_B, 0);
        step();
        clear_i = 1'b0;
        key_v_i = 1'b0;
        expect_at(cyc, KV_A, 0); expect_at(cyc, KV_B, 0);
        expect_at(cyc, RK_A, 0); expect_at(cyc, RK_B, s[5]);
        expect_at(cyc, KR_A, 1); expect_at(cyc + 1, RK_B, 0);
        step();
        step();
        sweep(s, 1'b0);

        // clear_i in eIdle
        clear_i = 1'b1;
        expect_at(cyc, KR_A, 0);
        step();
        clear_i = 1'b0;
        expect_at(cyc, KR_A, 1); expect_at(cyc, KV_A, 0);
        step();

        // Reset in the middle of an expansion
        k = {$urandom, $urandom, $urandom, $urandom};
        h = cyc;
        send_key(k, 0, '0);
        while (cyc < h + 11) step();
        reset_i = 1'b1;
        done_a_q.delete();
        expect_at(cyc, KR_A, 0); expect_at(cyc, KR_B, 0);
        expect_at(cyc, KV_A, 0); expect_at(cyc, KV_B, 0);
        expect_at(cyc, RK_A, 0); expect_at(cyc, RK_B, 0);
        expect_at(cyc, DN_A, 0);
        step();
        reset_i = 1'b0;
        expect_at(cyc, KR_A, 1); expect_at(cyc, KV_A, 0); expect_at(cyc, RK_A, 0);
        while (cyc < h + 40) step();
        sweep(ref_expand(k), 1'b0);

        k = {$urandom, $urandom, $urandom, $urandom};
        send_key(k, 0, '0);
        wait_done();
        sweep(ref_expand(k), 1'b1);

        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
